// File: rtl/tx_pkg.sv
// Shared types and widths for the burst serializer.
// TX_PARITY_EN adds the PARITY state to the encoding.
package tx_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
`ifdef TX_PARITY_EN
        ST_PARITY,
`endif
        ST_DONE
    } tx_state_e;

endpackage

// File: rtl/tx_bit_tick.sv
// Bit-period divider: counts 0..CLK_DIV-1, tick_o high on the last count.
// Latency 0 (tick is decoded from the count); clr_i forces the count back to 0.
module tx_bit_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_burst_serializer.sv
// Repeats a latched byte pattern serially for cfg_count bytes (0 = forever).
// First bit 1 cycle after accept; cfg_ready low while shifting or aborting. Option: TX_PARITY_EN.
module tx_burst_serializer
    import tx_pkg::*;
#(
    parameter int CLK_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] cfg_data,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              abort,
    output logic              tx_bit_data,
    output logic              tx_active,
    output logic              max_tx_flag
);

    tx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              flag_q, flag_d;
    logic              tick;
    logic              byte_done;
    logic [2:0]        bit_sel;

`ifdef TX_PARITY_EN
    assign tx_active = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
`else
    assign tx_active = (state_q == ST_SHIFT);
`endif

    assign cfg_ready   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !abort && !rst;
    assign max_tx_flag = flag_q;
    assign bit_sel     = (MSB_FIRST != 0) ? ~bit_idx_q : bit_idx_q;

    // Divider runs only while a bit is on the line, so every burst starts on a fresh period.
    tx_bit_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (!tx_active || abort),
        .tick_o(tick)
    );

    always_comb begin
        tx_bit_data = 1'b0;
        case (state_q)
            ST_SHIFT:  tx_bit_data = data_q[bit_sel];
`ifdef TX_PARITY_EN
            ST_PARITY: tx_bit_data = ^data_q;
`endif
            default:   tx_bit_data = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        count_d    = count_q;
        byte_cnt_d = byte_cnt_q;
        bit_idx_d  = bit_idx_q;
        flag_d     = flag_q;
        byte_done  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            flag_d  = 1'b0;
        end else if (cfg_valid && cfg_ready) begin
            data_d     = cfg_data;
            count_d    = cfg_count;
            byte_cnt_d = '0;
            bit_idx_d  = '0;
            flag_d     = 1'b0;
            state_d    = ST_SHIFT;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (tick) begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            byte_done = 1'b1;
`endif
                        end
                    end
                end
`ifdef TX_PARITY_EN
                ST_PARITY: byte_done = tick;
`endif
                default: ;
            endcase
            if (byte_done) begin
                byte_cnt_d = byte_cnt_q + 1'b1;
                if ((count_q != '0) && (byte_cnt_d == count_q)) begin
                    state_d = ST_DONE;
                    flag_d  = 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            bit_idx_q  <= '0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            count_q    <= count_d;
            byte_cnt_q <= byte_cnt_d;
            bit_idx_q  <= bit_idx_d;
            flag_q     <= flag_d;
        end
    end

endmodule

// File: tb/tb_tx_burst_serializer.sv
// Drives two serializer instances (CLK_DIV=1 MSB-first, CLK_DIV=3 LSB-first) with shared
// stimulus and compares every cycle against a closed-form bit-position model.
module tb_tx_burst_serializer;

`ifdef TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int DIVS [2] = '{1, 3};
    localparam int MSBF [2] = '{1, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_data;
    logic [31:0] cfg_count;
    logic        cfg_valid;
    logic        abort;
    logic [1:0]  rdy_w, bit_w, act_w, flg_w;

    int n_checks = 0;
    int n_errors = 0;

    // Model: whether a burst is running, the cycle it was accepted in, and its shadows.
    logic        busy  [2];
    int          start [2];
    logic [7:0]  m_dat [2];
    logic [31:0] m_cnt [2];
    logic        exp_rdy [2];
    int          cyc;

    always #5 clk = ~clk;

    tx_burst_serializer #(.CLK_DIV(1), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .cfg_valid(cfg_valid), .cfg_ready(rdy_w[0]), .abort(abort),
        .tx_bit_data(bit_w[0]), .tx_active(act_w[0]), .max_tx_flag(flg_w[0])
    );

    tx_burst_serializer #(.CLK_DIV(3), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .cfg_valid(cfg_valid), .cfg_ready(rdy_w[1]), .abort(abort),
        .tx_bit_data(bit_w[1]), .tx_active(act_w[1]), .max_tx_flag(flg_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_out(input int i, input logic ab, output logic b,
                                      output logic act, output logic flg, output logic rdy);
        int k, p, n, j;
        b = 1'b0; act = 1'b0; flg = 1'b0;
        if (busy[i]) begin
            k = cyc - start[i];
            p = (k - 1) / DIVS[i];
            n = p / NB;
            j = p % NB;
            if (m_cnt[i] != 0 && longint'(n) >= longint'(m_cnt[i])) begin
                flg = 1'b1;
            end else begin
                act = 1'b1;
                if (j == 8) b = ^m_dat[i];
                else if (MSBF[i] != 0) b = m_dat[i][7 - j];
                else b = m_dat[i][j];
            end
        end
        rdy = !act && !ab;
    endfunction

    // One clock cycle: apply inputs, compare outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic [31:0] n, input logic ab);
        logic b, act, flg, rdy;
        cfg_valid = v; cfg_data = d; cfg_count = n; abort = ab;
        #2;
        for (int i = 0; i < 2; i++) begin
            model_out(i, ab, b, act, flg, rdy);
            exp_rdy[i] = rdy;
            chk($sformatf("tx_bit_data[%0d]", i), 32'(bit_w[i]), 32'(b));
            chk($sformatf("tx_active[%0d]", i), 32'(act_w[i]), 32'(act));
            chk($sformatf("max_tx_flag[%0d]", i), 32'(flg_w[i]), 32'(flg));
            chk($sformatf("cfg_ready[%0d]", i), 32'(rdy_w[i]), 32'(rdy));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (ab) begin
                busy[i] = 1'b0;
            end else if (exp_rdy[i] && v) begin
                busy[i]  = 1'b1;
                start[i] = cyc;
                m_dat[i] = d;
                m_cnt[i] = n;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, 8'h00, 32'd0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_count = '0; abort = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            busy[i] = 1'b0; start[i] = 0; m_dat[i] = '0; m_cnt[i] = '0; exp_rdy[i] = 1'b0;
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_bit[%0d]", i), 32'(bit_w[i]), 32'd0);
            chk($sformatf("rst_active[%0d]", i), 32'(act_w[i]), 32'd0);
            chk($sformatf("rst_flag[%0d]", i), 32'(flg_w[i]), 32'd0);
            chk($sformatf("rst_ready[%0d]", i), 32'(rdy_w[i]), 32'd0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 0xA5 x2: instance a finishes after 16 bit cycles, flag visible at cycle 17.
        step(1'b1, 8'hA5, 32'd2, 1'b0);
        idle(16);
        #1;
        chk("a5_flag_cycle17", 32'(flg_w[0]), 32'd1);
        idle(40);

        // 0x01 x1: instance b holds bit0 for 3 cycles then zeros, flag at cycle 25.
        step(1'b1, 8'h01, 32'd1, 1'b0);
        idle(24);
        #1;
        chk("b_01_flag_cycle25", 32'(flg_w[1]), 32'd1);
        idle(4);

        // Restart straight from DONE.
        step(1'b1, 8'h42, 32'd1, 1'b0);
        idle(30);

        // Abort with a simultaneous offer: no accept, back to idle.
        step(1'b1, 8'h3C, 32'd5, 1'b0);
        idle(4);
        step(1'b1, 8'h11, 32'd3, 1'b1);
        idle(5);

        // Continuous burst with ignored offers while shifting.
        step(1'b1, 8'hFF, 32'd0, 1'b0);
        for (int c = 0; c < 1000; c++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom), 1'b0);
        step(1'b0, 8'h00, 32'd0, 1'b1);
        idle(3);

        // Asynchronous reset mid-byte, then accept on the first cycle after release.
        step(1'b1, 8'h5A, 32'd3, 1'b0);
        idle(5);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst_bit[%0d]", i), 32'(bit_w[i]), 32'd0);
            chk($sformatf("midrst_active[%0d]", i), 32'(act_w[i]), 32'd0);
            chk($sformatf("midrst_flag[%0d]", i), 32'(flg_w[i]), 32'd0);
            busy[i] = 1'b0;
        end
        #1;
        rst = 1'b0;
        #1;
        step(1'b1, 8'hC3, 32'd1, 1'b0);
        #0;
        chk("post_rst_accept_a", 32'(act_w[0]), 32'd1);
        idle(30);

        // Random traffic.
        for (int c = 0; c < 700; c++)
            step(1'($urandom_range(0, 9) == 0), 8'($urandom), 32'($urandom_range(0, 3)),
                 1'($urandom_range(0, 59) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tx_burst_serializer.md
TX_BURST_SERIALIZER -- requirements
Module: tx_burst_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1: clk cycles per transmitted bit, legal range 1..255.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit 7 first, 0 sends bit 0 first.
REQ-003 SHALL have port clk, input, 1: single clock for all logic (9.07 MHz transmit clock).
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port cfg_data, input, 8: byte pattern to transmit repeatedly.
REQ-006 SHALL have port cfg_count, input, 32: bytes per burst; 0 means continuous.
REQ-007 SHALL have port cfg_valid, input, 1: configuration offer.
REQ-008 SHALL have port cfg_ready, output, 1: configuration acceptance.
REQ-009 SHALL have port abort, input, 1: synchronous stop request.
REQ-010 SHALL have port tx_bit_data, output, 1: serial bit stream.
REQ-011 SHALL have port tx_active, output, 1: high while in SHIFT (or PARITY).
REQ-012 SHALL have port max_tx_flag, output, 1: burst complete, sticky until next accept, abort or reset.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY (only with TX_PARITY_EN) and DONE.
REQ-014 SHALL drive cfg_ready=1 in IDLE and DONE when abort=0, else 0; transfer occurs when cfg_valid&&cfg_ready on a rising clk edge.
REQ-015 On transfer, SHALL latch cfg_data and cfg_count into shadow registers, clear byte counter, bit index, divider and max_tx_flag, and enter SHIFT.
REQ-016 SHALL present the first bit on tx_bit_data in the cycle after transfer (latency 1).
REQ-017 SHALL hold each bit for exactly CLK_DIV cycles; the divider counts 0..CLK_DIV-1, and a bit tick occurs at CLK_DIV-1.
REQ-018 After 8 bit ticks, SHALL increment the 32-bit byte counter and restart the byte with no idle gap.
REQ-019 With nonzero count, when byte counter reaches shadow count, SHALL enter DONE in the same cycle as the last tick; max_tx_flag=1 next cycle.
REQ-020 With count 0, SHALL stay in SHIFT indefinitely; the byte counter wraps 0xFFFFFFFF->0 and max_tx_flag never sets.
REQ-021 SHALL drive tx_bit_data=0 in IDLE and DONE.
REQ-022 abort=1 in any state SHALL force IDLE next cycle, clear max_tx_flag, tx_active and tx_bit_data; abort wins over simultaneous cfg_valid.
REQ-023 cfg_valid during SHIFT SHALL be ignored (cfg_ready=0); shadow registers SHALL not change mid-burst.
REQ-024 A new transfer in DONE SHALL restart a burst directly (DONE->SHIFT).

Reset
REQ-025 On rst=1, SHALL asynchronously enter IDLE with tx_bit_data=0, tx_active=0, max_tx_flag=0, and all counters and shadows cleared; cfg_ready rises the first cycle after rst deasserts.

Configuration
REQ-026 With TX_PARITY_EN defined, SHALL append after each byte one even-parity bit (XOR of shadow byte) held CLK_DIV cycles in state PARITY, then count the byte.
REQ-027 Without TX_PARITY_EN, PARITY state and logic SHALL not exist and bytes are exactly 8 bit periods back-to-back.

Structure
REQ-028 Package tx_pkg SHALL hold the state enum, byte width constant 8, and counter width constant 32.
REQ-029 SHALL instantiate one sub-module tx_bit_tick (CLK_DIV divider with clear input and tick output).

Verification
REQ-030 CLK_DIV=1, MSB_FIRST=1, data 0xA5, count 2 -> tx_bit_data 1,0,1,0,0,1,0,1 twice from cycle 1; max_tx_flag=1 at cycle 17.
REQ-031 CLK_DIV=3, data 0x01, count 1, MSB_FIRST=0 -> bit0=1 held cycles 1-3, then 0 for 21 cycles; DONE at cycle 24.
REQ-032 count 0, data 0xFF, run 1000 cycles -> tx_bit_data constant 1, tx_active=1, max_tx_flag=0.
REQ-033 abort at cycle 5 of burst with cfg_valid=1 simultaneously -> IDLE next cycle, cfg_ready=0 that cycle, outputs 0, no accept.
REQ-034 rst pulsed mid-byte, asynchronously off-edge -> outputs 0 immediately; accept on first post-reset cycle.
REQ-035 TX_PARITY_EN, data 0x07, count 1 -> 9 bits with parity 1; flag at cycle 10.
